cayde_issue: RTL and testbench

- Operand-issue stage for the cayde RV32I core; the producer side of the ALU interface.
- Accepts fetched instructions and decodes OP, OP-IMM and LUI into a cayde_pkg::alu_op plus two 32-bit operands.
- Owns the 31x32 integer register file and a per-register busy scoreboard.
- Presents a registered valid/ready issue slot to the execute stage, where the ALU sits.

---
 rtl/cayde_issue.sv | 228 ++++++++++++++++++++++
 tb/tb_cayde_issue.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cayde_issue.sv
// cayde_issue: operand-issue stage of the cayde RV32I core.
// Decodes OP / OP-IMM / LUI into an ALU operation with two operands.
// Owns the integer register file and its busy scoreboard.
// Feeds a registered valid/ready slot to the execute stage.

package cayde_pkg;
  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND
  } alu_op;
endpackage

module cayde_issue #(
  parameter int NREGS = 32,
  parameter int XLEN  = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   instr_valid_i,
  input  logic [31:0]            instr_i,
  output logic                   instr_ready_o,
  input  logic                   wb_en_i,
  input  logic [4:0]             wb_rd_i,
  input  logic [XLEN-1:0]        wb_data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output cayde_pkg::alu_op       op_o,
  output logic [XLEN-1:0]        op_a_o,
  output logic [XLEN-1:0]        op_b_o,
  output logic [4:0]             rd_o,
  output logic                   illegal_o
);
  import cayde_pkg::*;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  // Architectural state: register file, scoreboard and the issue slot
  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_busy;
  logic             r_valid;
  alu_op            r_op;
  logic [XLEN-1:0]  r_opA;
  logic [XLEN-1:0]  r_opB;
  logic [4:0]       r_rd;
  logic             r_illegal;

  // Instruction fields
  logic [6:0] w_opcode;
  logic [6:0] w_funct7;
  logic [2:0] w_funct3;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic [4:0] w_rdField;

  assign w_opcode  = instr_i[6:0];
  assign w_rdField = instr_i[11:7];
  assign w_funct3  = instr_i[14:12];
  assign w_rs1     = instr_i[19:15];
  assign w_rs2     = instr_i[24:20];
  assign w_funct7  = instr_i[31:25];

  // Source operand values with writeback bypass; x0 always reads zero
  logic [XLEN-1:0] w_rs1Val;
  logic [XLEN-1:0] w_rs2Val;

  assign w_rs1Val = (w_rs1 == 5'd0) ? '0 :
                    (wb_en_i && wb_rd_i == w_rs1) ? wb_data_i : r_regs[w_rs1];
  assign w_rs2Val = (w_rs2 == 5'd0) ? '0 :
                    (wb_en_i && wb_rd_i == w_rs2) ? wb_data_i : r_regs[w_rs2];

  // Decoded slot contents
  alu_op           w_op;
  logic [XLEN-1:0] w_opA;
  logic [XLEN-1:0] w_opB;
  logic [4:0]      w_rd;
  logic            w_legal;
  logic            w_useRs1;
  logic            w_useRs2;

  // Decode the instruction; anything unsupported collapses to a harmless illegal ADD
  always_comb begin
    w_op     = ALU_ADD;
    w_opA    = '0;
    w_opB    = '0;
    w_rd     = w_rdField;
    w_legal  = 1'b0;
    w_useRs1 = 1'b0;
    w_useRs2 = 1'b0;
    case (w_opcode)
      OPC_OP: begin
        w_useRs1 = 1'b1;
        w_useRs2 = 1'b1;
        w_opA    = w_rs1Val;
        w_opB    = w_rs2Val;
        w_legal  = (w_funct7 == F7_ZERO) ||
                   (w_funct7 == F7_ALT && (w_funct3 == 3'b000 || w_funct3 == 3'b101));
        case (w_funct3)
          3'b000:  w_op = (w_funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
          3'b001:  w_op = ALU_SLL;
          3'b010:  w_op = ALU_SLT;
          3'b011:  w_op = ALU_SLTU;
          3'b100:  w_op = ALU_XOR;
          3'b101:  w_op = (w_funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
          3'b110:  w_op = ALU_OR;
          default: w_op = ALU_AND;
        endcase
      end
      OPC_OP_IMM: begin
        w_useRs1 = 1'b1;
        w_opA    = w_rs1Val;
        w_opB    = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
        w_legal  = 1'b1;
        case (w_funct3)
          3'b000:  w_op = ALU_ADD;
          3'b001: begin
            w_op    = ALU_SLL;
            w_opB   = {{(XLEN-5){1'b0}}, instr_i[24:20]};
            w_legal = (w_funct7 == F7_ZERO);
          end
          3'b010:  w_op = ALU_SLT;
          3'b011:  w_op = ALU_SLTU;
          3'b100:  w_op = ALU_XOR;
          3'b101: begin
            w_op    = (w_funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            w_opB   = {{(XLEN-5){1'b0}}, instr_i[24:20]};
            w_legal = (w_funct7 == F7_ZERO) || (w_funct7 == F7_ALT);
          end
          3'b110:  w_op = ALU_OR;
          default: w_op = ALU_AND;
        endcase
      end
      OPC_LUI: begin
        w_legal = 1'b1;
        w_opB   = {instr_i[31:12], {(XLEN-20){1'b0}}};
      end
      default: w_legal = 1'b0;
    endcase
    if (!w_legal) begin
      w_op     = ALU_ADD;
      w_opA    = '0;
      w_opB    = '0;
      w_rd     = 5'd0;
      w_useRs1 = 1'b0;
      w_useRs2 = 1'b0;
    end
  end

  // Scoreboard view: a register retiring this cycle no longer counts as busy
  logic [NREGS-1:0] w_wbMask;
  logic [NREGS-1:0] w_effBusy;
  logic [NREGS-1:0] w_setMask;
  logic             w_hazard;
  logic             w_slotFree;
  logic             w_fire;

  assign w_wbMask   = wb_en_i ? ({{(NREGS-1){1'b0}}, 1'b1} << wb_rd_i) : '0;
  assign w_effBusy  = r_busy & ~w_wbMask;
  assign w_hazard   = (w_useRs1 && w_rs1 != 5'd0 && w_effBusy[w_rs1]) ||
                      (w_useRs2 && w_rs2 != 5'd0 && w_effBusy[w_rs2]) ||
                      (w_rd != 5'd0 && w_effBusy[w_rd]);
  assign w_slotFree = !r_valid || out_ready_i;
  assign w_fire     = instr_valid_i && instr_ready_o;
  assign w_setMask  = (w_fire && w_legal && w_rd != 5'd0) ?
                      ({{(NREGS-1){1'b0}}, 1'b1} << w_rd) : '0;

  assign instr_ready_o = w_slotFree && !w_hazard;

  // Issue slot: load on accept, drop when consumed, otherwise hold stable
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid   <= 1'b0;
      r_op      <= ALU_ADD;
      r_opA     <= '0;
      r_opB     <= '0;
      r_rd      <= 5'd0;
      r_illegal <= 1'b0;
    end else if (w_fire) begin
      r_valid   <= 1'b1;
      r_op      <= w_op;
      r_opA     <= w_opA;
      r_opB     <= w_opB;
      r_rd      <= w_rd;
      r_illegal <= !w_legal;
    end else if (out_ready_i) begin
      r_valid   <= 1'b0;
    end
  end

  // Busy bits: writeback clears, a legal accept sets, and the set takes priority
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~w_wbMask) | w_setMask;
    end
  end

  // Register file: writeback is never stalled and x0 stays zero
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (wb_en_i && wb_rd_i != 5'd0) begin
      r_regs[wb_rd_i] <= wb_data_i;
    end
  end

  assign out_valid_o = r_valid;
  assign op_o        = r_op;
  assign op_a_o      = r_opA;
  assign op_b_o      = r_opB;
  assign rd_o        = r_rd;
  assign illegal_o   = r_illegal;

endmodule

// File: tb/tb_cayde_issue.sv
// tb_cayde_issue: directed and randomized checks of the cayde issue stage
// against a behavioural model of register file, scoreboard and issue slot.

module tb_cayde_issue;
  import cayde_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        instr_valid_i;
  logic [31:0] instr_i;
  logic        instr_ready_o;
  logic        wb_en_i;
  logic [4:0]  wb_rd_i;
  logic [31:0] wb_data_i;
  logic        out_valid_o;
  logic        out_ready_i;
  alu_op       op_o;
  logic [31:0] op_a_o;
  logic [31:0] op_b_o;
  logic [4:0]  rd_o;
  logic        illegal_o;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] mRegs [32];
  bit          mBusy [32];
  bit          mValid;
  alu_op       mOp;
  logic [31:0] mA;
  logic [31:0] mB;
  logic [4:0]  mRd;
  bit          mIll;

  typedef struct {
    alu_op       op;
    bit          legal;
    bit          useRs1;
    bit          useRs2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } dec_t;

  // Free-running clock
  always #5 clk = ~clk;

  cayde_issue #(.NREGS(32), .XLEN(32)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .instr_valid_i (instr_valid_i),
    .instr_i       (instr_i),
    .instr_ready_o (instr_ready_o),
    .wb_en_i       (wb_en_i),
    .wb_rd_i       (wb_rd_i),
    .wb_data_i     (wb_data_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .op_o          (op_o),
    .op_a_o        (op_a_o),
    .op_b_o        (op_b_o),
    .rd_o          (rd_o),
    .illegal_o     (illegal_o)
  );

  // Table-driven decode straight from the instruction-set rules
  function automatic dec_t modelDecode(input logic [31:0] ins);
    alu_op       baseOps [8];
    dec_t        d;
    logic [6:0]  f7;
    logic [2:0]  f3;
    baseOps = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    f7       = ins[31:25];
    f3       = ins[14:12];
    d.op     = ALU_ADD;
    d.legal  = 1'b0;
    d.useRs1 = 1'b0;
    d.useRs2 = 1'b0;
    d.imm    = 32'd0;
    d.rs1    = ins[19:15];
    d.rs2    = ins[24:20];
    d.rd     = ins[11:7];
    if (ins[6:0] == 7'h33) begin
      d.useRs1 = 1'b1;
      d.useRs2 = 1'b1;
      d.op     = baseOps[f3];
      if (f7 == 7'h00) begin
        d.legal = 1'b1;
      end else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) begin
        d.legal = 1'b1;
        d.op    = (f3 == 3'd0) ? ALU_SUB : ALU_SRA;
      end
    end else if (ins[6:0] == 7'h13) begin
      d.useRs1 = 1'b1;
      d.op     = baseOps[f3];
      if (f3 == 3'd1 || f3 == 3'd5) begin
        d.imm = {27'd0, ins[24:20]};
        if (f7 == 7'h00) begin
          d.legal = 1'b1;
        end else if (f7 == 7'h20 && f3 == 3'd5) begin
          d.legal = 1'b1;
          d.op    = ALU_SRA;
        end
      end else begin
        d.legal = 1'b1;
        d.imm   = 32'($signed(ins[31:20]));
      end
    end else if (ins[6:0] == 7'h37) begin
      d.legal = 1'b1;
      d.imm   = {ins[31:12], 12'h000};
    end
    if (!d.legal) begin
      d.op     = ALU_ADD;
      d.useRs1 = 1'b0;
      d.useRs2 = 1'b0;
      d.rd     = 5'd0;
    end
    return d;
  endfunction

  function automatic bit effBusy(input logic [4:0] r, input bit we, input logic [4:0] wr);
    return (r != 5'd0) && mBusy[r] && !(we && wr == r);
  endfunction

  function automatic logic [31:0] readReg(input logic [4:0] r, input bit we,
                                          input logic [4:0] wr, input logic [31:0] wd);
    if (r == 5'd0) return 32'd0;
    if (we && wr == r) return wd;
    return mRegs[r];
  endfunction

  function automatic logic [31:0] rType(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic checkSlot(input string tag, input bit full);
    checkOutput({tag, ".valid"}, {31'd0, out_valid_o}, {31'd0, mValid});
    if (mValid || full) begin
      checkOutput({tag, ".illegal"}, {31'd0, illegal_o}, {31'd0, mIll});
      checkOutput({tag, ".op"},      32'(op_o),          32'(mOp));
      checkOutput({tag, ".opA"},     op_a_o,             mA);
      checkOutput({tag, ".opB"},     op_b_o,             mB);
      checkOutput({tag, ".rd"},      {27'd0, rd_o},      {27'd0, mRd});
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 32; i++) begin
      mRegs[i] = 32'd0;
      mBusy[i] = 1'b0;
    end
    mValid = 1'b0;
    mOp    = ALU_ADD;
    mA     = 32'd0;
    mB     = 32'd0;
    mRd    = 5'd0;
    mIll   = 1'b0;
  endtask

  task automatic resetCycle(input string tag);
    rst_i         = 1'b1;
    instr_valid_i = 1'b0;
    instr_i       = 32'd0;
    wb_en_i       = 1'b0;
    wb_rd_i       = 5'd0;
    wb_data_i     = 32'd0;
    out_ready_i   = 1'b0;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    modelReset();
    checkSlot(tag, 1'b1);
  endtask

  // One cycle: drive inputs, check ready mid-cycle, advance model and DUT, check slot
  task automatic applyStimulus(input bit iv, input logic [31:0] ins, input bit we,
                               input logic [4:0] wr, input logic [31:0] wd,
                               input bit ordy, input string tag);
    dec_t d;
    bit   expReady;
    bit   fire;
    instr_valid_i = iv;
    instr_i       = ins;
    wb_en_i       = we;
    wb_rd_i       = wr;
    wb_data_i     = wd;
    out_ready_i   = ordy;
    #3;
    d = modelDecode(ins);
    expReady = (!mValid || ordy) &&
               !((d.useRs1 && effBusy(d.rs1, we, wr)) ||
                 (d.useRs2 && effBusy(d.rs2, we, wr)) ||
                 effBusy(d.rd, we, wr));
    checkOutput({tag, ".ready"}, {31'd0, instr_ready_o}, {31'd0, expReady});
    fire = iv && expReady;
    if (fire) begin
      mValid = 1'b1;
      mIll   = !d.legal;
      mOp    = d.op;
      mRd    = d.rd;
      mA     = d.useRs1 ? readReg(d.rs1, we, wr, wd) : 32'd0;
      mB     = d.useRs2 ? readReg(d.rs2, we, wr, wd) : d.imm;
      if (!d.legal) begin
        mA = 32'd0;
        mB = 32'd0;
      end
    end else if (ordy) begin
      mValid = 1'b0;
    end
    if (we) begin
      mBusy[wr] = 1'b0;
      if (wr != 5'd0) mRegs[wr] = wd;
    end
    if (fire && d.legal && d.rd != 5'd0) mBusy[d.rd] = 1'b1;
    @(posedge clk);
    #1;
    checkSlot(tag, 1'b0);
  endtask

  function automatic logic [31:0] randInstr();
    logic [6:0] opc;
    logic [6:0] f7;
    logic [2:0] f3;
    int         kind;
    int         f7Pick;
    kind   = $urandom_range(0, 9);
    f3     = 3'($urandom_range(0, 7));
    f7Pick = $urandom_range(0, 3);
    f7     = (f7Pick == 0) ? 7'h00 : (f7Pick == 1) ? 7'h20 : 7'($urandom);
    if (kind < 4) begin
      opc = 7'h33;
    end else if (kind < 8) begin
      opc = 7'h13;
      if (f3 != 3'd1 && f3 != 3'd5) f7 = 7'($urandom);
    end else if (kind == 8) begin
      opc = 7'h37;
      f7  = 7'($urandom);
    end else begin
      opc = 7'($urandom);
      if (opc == 7'h33 || opc == 7'h13 || opc == 7'h37) opc = 7'h73;
    end
    return rType(f7, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), f3,
                 5'($urandom_range(0, 7)), opc);
  endfunction

  initial begin
    logic [31:0] addX3;
    logic [31:0] subX6;
    logic [31:0] addX7;
    logic [31:0] sraiX5;
    logic [31:0] rIns;
    addX3  = rType(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33);
    subX6  = rType(7'h20, 5'd1, 5'd3, 3'd0, 5'd6, 7'h33);
    addX7  = rType(7'h00, 5'd2, 5'd1, 3'd0, 5'd7, 7'h33);
    sraiX5 = rType(7'h20, 5'd31, 5'd4, 3'd5, 5'd5, 7'h13);

    $display("[TB] start");
    resetCycle("reset0");
    resetCycle("reset1");

    applyStimulus(1'b0, 32'd0, 1'b1, 5'd1, 32'd5, 1'b1, "wbX1");
    applyStimulus(1'b0, 32'd0, 1'b1, 5'd2, 32'd3, 1'b1, "wbX2");
    applyStimulus(1'b1, addX3, 1'b0, 5'd0, 32'd0, 1'b1, "addX3");
    checkOutput("addX3.constA", op_a_o, 32'd5);
    checkOutput("addX3.constB", op_b_o, 32'd3);

    applyStimulus(1'b1, 32'hFFF00213, 1'b0, 5'd0, 32'd0, 1'b1, "addiX4");
    checkOutput("addiX4.constB", op_b_o, 32'hFFFFFFFF);
    applyStimulus(1'b1, sraiX5, 1'b1, 5'd4, 32'hFFFFFFFF, 1'b1, "sraiX5");
    checkOutput("sraiX5.constOp", 32'(op_o), 32'(ALU_SRA));
    checkOutput("sraiX5.constB", op_b_o, 32'd31);

    applyStimulus(1'b1, subX6, 1'b0, 5'd0, 32'd0, 1'b1, "rawStall");
    checkOutput("rawStall.constReady", {31'd0, instr_ready_o}, 32'd0);
    applyStimulus(1'b1, subX6, 1'b1, 5'd3, 32'd8, 1'b1, "rawBypass");
    checkOutput("rawBypass.constA", op_a_o, 32'd8);
    checkOutput("rawBypass.constOp", 32'(op_o), 32'(ALU_SUB));

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, addX7, 1'b0, 5'd0, 32'd0, 1'b0, "backpressure");
    end
    applyStimulus(1'b1, addX7, 1'b0, 5'd0, 32'd0, 1'b1, "backToBack");
    checkOutput("backToBack.constRd", {27'd0, rd_o}, 32'd7);

    applyStimulus(1'b1, 32'h123453B7, 1'b1, 5'd7, 32'd0, 1'b1, "luiX7");
    checkOutput("luiX7.constB", op_b_o, 32'h12345000);
    applyStimulus(1'b1, 32'h00000073, 1'b0, 5'd0, 32'd0, 1'b1, "illegal");
    checkOutput("illegal.constFlag", {31'd0, illegal_o}, 32'd1);

    applyStimulus(1'b1, addX3, 1'b0, 5'd0, 32'd0, 1'b1, "preReset");
    applyStimulus(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, "preResetHold");
    resetCycle("midReset");
    applyStimulus(1'b1, addX3, 1'b0, 5'd0, 32'd0, 1'b1, "postReset");

    for (int n = 0; n < 400; n++) begin
      rIns = randInstr();
      applyStimulus(1'($urandom_range(0, 3) != 0), rIns,
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                    1'($urandom_range(0, 3) != 0), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
